// File: rtl/fpu_mem_slave.sv
// Word memory behind the FPU load/store port: one request at a time, configurable
// response latency, byte strobes, error reporting and a stall hook for wait states.
module fpu_mem_slave #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_we,
  input  logic                  mem_re,
  input  logic                  stall_i,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_err,
  output logic                  busy
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT    = (ADDR_W+1)'(DEPTH * NB);
  localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_r, state_nx_s;
  logic [3:0]            cnt_r;
  logic [DATA_W-1:0]     ram_r [DEPTH];

  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     wdata_r;
  logic [NB-1:0]         wstrb_r;
  logic                  we_r;
  logic                  acc_err_r;

  logic                  req_s;
  logic                  live_err_s;
  logic [ADDR_W-1:0]     sel_addr_s;
  logic [DATA_W-1:0]     sel_wdata_s;
  logic [NB-1:0]         sel_wstrb_s;
  logic                  sel_we_s;
  logic                  sel_err_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  enter_resp_s;

  logic [DATA_W-1:0]     rdata_r;
  logic                  ready_r;
  logic                  err_r;
  logic                  busy_r;

  assign req_s = mem_re | mem_we;

  // Classify the live request: misaligned, beyond the array, or both ops at once
  always_comb begin
    live_err_s = (|mem_addr[OFF-1:0]) | ({1'b0, mem_addr} >= LIMIT) | (mem_re & mem_we);
  end

  // With LATENCY=1 the response is entered straight from IDLE, so use the live inputs there
  always_comb begin
    sel_addr_s  = addr_r;
    sel_wdata_s = wdata_r;
    sel_wstrb_s = wstrb_r;
    sel_we_s    = we_r;
    sel_err_s   = acc_err_r;
    if (state_r == S_IDLE) begin
      sel_addr_s  = mem_addr;
      sel_wdata_s = mem_wdata;
      sel_wstrb_s = mem_wstrb;
      sel_we_s    = mem_we;
      sel_err_s   = live_err_s;
    end else begin
      sel_addr_s  = addr_r;
    end
  end

  assign idx_s = sel_addr_s[OFF +: IDX_W];

  // Next-state decode; enter_resp_s marks the edge that commits stores and samples loads
  always_comb begin
    state_nx_s   = state_r;
    enter_resp_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          if (LATENCY == 1) begin
            state_nx_s   = S_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_nx_s   = S_WAIT;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!stall_i && (cnt_r == 4'd1)) begin
          state_nx_s   = S_RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_nx_s   = S_WAIT;
        end
      end
      S_RESP:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nx_s;
  end

  // Latency counter; frozen by stall_i while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (state_r == S_IDLE && req_s) begin
      cnt_r <= CNT_INIT;
    end else if (state_r == S_WAIT && !stall_i) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Request capture at the sampling edge; inputs are ignored afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r    <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      we_r      <= 1'b0;
      acc_err_r <= 1'b0;
    end else if (state_r == S_IDLE && req_s) begin
      addr_r    <= mem_addr;
      wdata_r   <= mem_wdata;
      wstrb_r   <= mem_wstrb;
      we_r      <= mem_we;
      acc_err_r <= live_err_s;
    end else begin
      addr_r    <= addr_r;
    end
  end

  // Store commit; gated by rst_n so a reset-aborted request never writes
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp_s && sel_we_s && !sel_err_s) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_wstrb_s[b]) ram_r[idx_s][8*b +: 8] <= sel_wdata_s[8*b +: 8];
      end
    end
  end

  // Response outputs: one-cycle ready pulse, data only while ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= '0;
      busy_r  <= 1'b0;
    end else begin
      ready_r <= enter_resp_s;
      err_r   <= enter_resp_s & sel_err_s;
      if (enter_resp_s && !sel_we_s && !sel_err_s) rdata_r <= ram_r[idx_s];
      else                                         rdata_r <= '0;
      if (enter_resp_s)                        busy_r <= 1'b0;
      else if (state_r == S_IDLE && req_s)     busy_r <= 1'b1;
      else                                     busy_r <= busy_r;
    end
  end

  assign mem_rdata = rdata_r;
  assign mem_ready = ready_r;
  assign mem_err   = err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_fpu_mem_slave.sv
// Bench for fpu_mem_slave: four instances with LATENCY 1..4, a cycle-indexed response
// model checked every cycle, plus literal expectations for the directed scenarios.
module tb_fpu_mem_slave;

  logic        clk = 1'b0;
  logic [3:0]  rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [3:0]  re;
  logic [3:0]  we;
  logic        stall;
  logic [31:0] rdata [4];
  logic [3:0]  ready;
  logic [3:0]  err;
  logic [3:0]  busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // model: per instance, expected response window and payload
  bit          ea [4];
  int          es [4];
  int          er [4];
  logic        ee [4];
  logic [31:0] ed [4];
  logic [31:0] mdl [4][4096];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    fpu_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(4096), .LATENCY(g + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .mem_addr  (addr),
      .mem_wdata (wdata),
      .mem_wstrb (wstrb),
      .mem_we    (we[g]),
      .mem_re    (re[g]),
      .stall_i   (stall),
      .mem_rdata (rdata[g]),
      .mem_ready (ready[g]),
      .mem_err   (err[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    logic rx;
    logic bx;
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        rx = ea[i] && (cyc == er[i]);
        bx = ea[i] && (cyc >= es[i]) && (cyc < er[i]);
        check($sformatf("ready%0d", i), 32'(ready[i]), 32'(rx));
        check($sformatf("busy%0d", i),  32'(busy[i]),  32'(bx));
        check($sformatf("err%0d", i),   32'(err[i]),   rx ? 32'(ee[i]) : 32'd0);
        check($sformatf("rdata%0d", i), rdata[i],      rx ? ed[i] : 32'd0);
      end
    end
  end

  // issue one request on instance i (LATENCY i+1); optionally stall nst cycles or reset in WAIT
  task automatic req(input int i, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] sb, input int nst,
                     input bit do_rst, output logic [31:0] gd, output logic ge, output int lat);
    int   s;
    bit   found;
    logic e;
    int   idx;
    gd = 32'd0; ge = 1'b0; lat = 0; found = 1'b0;
    @(posedge clk); #2;
    s   = cyc + 1;
    idx = int'(a[13:2]);
    e   = (a[1:0] != 2'd0) || (a >= 32'h0000_4000) || (r && w);
    ea[i] = 1'b1;
    es[i] = s;
    er[i] = s + i + nst;
    ee[i] = e;
    ed[i] = (r && !w && !e) ? mdl[i][idx] : 32'd0;
    addr = a; wdata = d; wstrb = sb; re[i] = r; we[i] = w;
    stall = (nst > 0);
    if (do_rst) begin
      @(posedge clk); #2;
      rst_n[i] = 1'b0;
      ea[i] = 1'b0;
      re[i] = 1'b0; we[i] = 1'b0;
      #1;
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_ready", 32'(ready[i]), 32'd0);
      @(posedge clk); #2;
      rst_n[i] = 1'b1;
      return;
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (cyc >= s + nst) stall = 1'b0;
      if (ready[i]) begin
        found = 1'b1;
        gd  = rdata[i];
        ge  = err[i];
        lat = cyc - s + 1;
        break;
      end
    end
    re[i] = 1'b0; we[i] = 1'b0; stall = 1'b0;
    if (!found) begin
      total++; bad++;
      ea[i] = 1'b0;
      $display("FAIL timeout inst=%0d got=no_ready exp=ready", i);
    end else if (w && !r && !e) begin
      for (int b = 0; b < 4; b++)
        if (sb[b]) mdl[i][idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  initial begin
    logic [31:0] gd;
    logic        ge;
    int          lat;
    rst_n = 4'h0; re = 4'h0; we = 4'h0; stall = 1'b0;
    addr = 32'd0; wdata = 32'd0; wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      ea[i] = 1'b0; es[i] = 0; er[i] = 0; ee[i] = 1'b0; ed[i] = 32'd0;
    end
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(posedge clk); #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(ready), 32'd0);
    rst_n = 4'hF;

    // 1: legacy latency store/load
    req(0, 1'b0, 1'b1, 32'h100, 32'h3F80_0000, 4'hF, 0, 1'b0, gd, ge, lat);
    check("t1_st_lat", 32'(lat), 32'd1);
    check("t1_st_err", 32'(ge), 32'd0);
    req(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b0, gd, ge, lat);
    check("t1_ld_lat", 32'(lat), 32'd1);
    check("t1_ld_data", gd, 32'h3F80_0000);
    check("t1_ld_err", 32'(ge), 32'd0);

    // 2: latency 4
    req(3, 1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 0, 1'b0, gd, ge, lat);
    req(3, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b0, gd, ge, lat);
    check("t2_lat", 32'(lat), 32'd4);
    check("t2_data", gd, 32'hCAFE_F00D);

    // 3: byte strobes, zero strobe
    req(0, 1'b0, 1'b1, 32'h8, 32'h1122_3344, 4'hF, 0, 1'b0, gd, ge, lat);
    req(0, 1'b0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'h5, 0, 1'b0, gd, ge, lat);
    req(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0, gd, ge, lat);
    check("t3_strb", gd, 32'h11BB_33DD);
    req(0, 1'b0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, gd, ge, lat);
    check("t3_z_err", 32'(ge), 32'd0);
    req(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0, gd, ge, lat);
    check("t3_zero_strb", gd, 32'h11BB_33DD);

    // 4: error cases and the last valid word
    req(0, 1'b1, 1'b0, 32'h102, 32'h0, 4'h0, 0, 1'b0, gd, ge, lat);
    check("t4_mis_err", 32'(ge), 32'd1);
    check("t4_mis_data", gd, 32'd0);
    req(0, 1'b1, 1'b0, 32'h4000, 32'h0, 4'h0, 0, 1'b0, gd, ge, lat);
    check("t4_oor_err", 32'(ge), 32'd1);
    req(0, 1'b1, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, gd, ge, lat);
    check("t4_both_err", 32'(ge), 32'd1);
    check("t4_both_data", gd, 32'd0);
    req(0, 1'b0, 1'b1, 32'h4000, 32'h5555_5555, 4'hF, 0, 1'b0, gd, ge, lat);
    check("t4_oor_st_err", 32'(ge), 32'd1);
    req(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b0, gd, ge, lat);
    check("t4_unchanged", gd, 32'h3F80_0000);
    req(0, 1'b0, 1'b1, 32'h3FFC, 32'h0BAD_F00D, 4'hF, 0, 1'b0, gd, ge, lat);
    req(0, 1'b1, 1'b0, 32'h3FFC, 32'h0, 4'h0, 0, 1'b0, gd, ge, lat);
    check("t4_top_err", 32'(ge), 32'd0);
    check("t4_top_data", gd, 32'h0BAD_F00D);

    // 5: stall during WAIT, latency 2
    req(1, 1'b0, 1'b1, 32'h10, 32'h7777_0001, 4'hF, 0, 1'b0, gd, ge, lat);
    check("t5_nostall_lat", 32'(lat), 32'd2);
    req(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 3, 1'b0, gd, ge, lat);
    check("t5_stall_lat", 32'(lat), 32'd5);
    check("t5_data", gd, 32'h7777_0001);

    // 6: reset during WAIT aborts the store, latency 3
    req(2, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, 1'b0, gd, ge, lat);
    check("t6_lat", 32'(lat), 32'd3);
    req(2, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, gd, ge, lat);
    repeat (4) @(posedge clk);
    req(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, gd, ge, lat);
    check("t6_kept", gd, 32'h1234_5678);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
